// File: rtl/fifo_frame_reader.sv
// fifo_frame_reader: pops one ADC frame per read request and serialises it MSB-first on SCK.
// Define CRC8_EN to append a serial CRC-8 trailer to every frame.
module fifo_frame_reader #(
  parameter int unsigned FRAME_BITS = 128
`ifdef CRC8_EN
  ,
  parameter logic [7:0]  CRC_POLY   = 8'h07
`endif
) (
  input  logic                  SCK,
  input  logic                  RST_sync,
  input  logic                  ENSAMP_sync,
  input  logic                  DATA_RDY,
  input  logic                  RD_REQ,
  input  logic                  RD_CONT,
  input  logic                  RD_ABORT,
  input  logic [FRAME_BITS-1:0] ADC_data,
  output logic                  FIFO_POP,
  output logic                  MISO_data,
  output logic                  BUSY,
  output logic                  FRAME_DONE,
  output logic                  DRDY_AT_LOAD
);

  localparam int unsigned      CNT_W    = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1
`ifdef CRC8_EN
    ,
    ST_CRC   = 2'd2
`endif
  } state_t;

  state_t                state_q, state_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]      bitcnt_q, bitcnt_d;
  logic                  pop_q, pop_d;
  logic                  drdy_load_q, drdy_load_d;
`ifdef CRC8_EN
  logic [7:0]            crc_q, crc_d;
`endif

  logic ens_meta_q, ens_s_q, drdy_meta_q, drdy_s_q;
  logic abort_c, load_c, eof_c, miso_c, busy_c, done_c;

  // Two-flop synchronisers for the foreign-domain level inputs
  always_ff @(posedge SCK) begin
    if (RST_sync) begin
      ens_meta_q  <= 1'b0;
      ens_s_q     <= 1'b0;
      drdy_meta_q <= 1'b0;
      drdy_s_q    <= 1'b0;
    end else begin
      ens_meta_q  <= ENSAMP_sync;
      ens_s_q     <= ens_meta_q;
      drdy_meta_q <= DATA_RDY;
      drdy_s_q    <= drdy_meta_q;
    end
  end

  always_ff @(posedge SCK) begin
    if (RST_sync) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      bitcnt_q    <= '0;
      pop_q       <= 1'b0;
      drdy_load_q <= 1'b0;
`ifdef CRC8_EN
      crc_q       <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bitcnt_q    <= bitcnt_d;
      pop_q       <= pop_d;
      drdy_load_q <= drdy_load_d;
`ifdef CRC8_EN
      crc_q       <= crc_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bitcnt_d    = bitcnt_q;
    pop_d       = 1'b0;
    drdy_load_d = drdy_load_q;
`ifdef CRC8_EN
    crc_d       = crc_q;
`endif
    abort_c     = RD_ABORT || !ens_s_q;
    load_c      = 1'b0;
    eof_c       = 1'b0;
    miso_c      = 1'b0;
    busy_c      = 1'b0;
    done_c      = 1'b0;

    case (state_q)
      ST_IDLE: load_c = RD_REQ;
      ST_SHIFT: begin
        miso_c   = shreg_q[FRAME_BITS-1];
        busy_c   = 1'b1;
        shreg_d  = {shreg_q[FRAME_BITS-2:0], 1'b0};
        bitcnt_d = bitcnt_q + CNT_W'(1);
`ifdef CRC8_EN
        crc_d = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ shreg_q[FRAME_BITS-1]) ? CRC_POLY : 8'h00);
        if (bitcnt_q == LAST_BIT) begin
          state_d  = ST_CRC;
          bitcnt_d = '0;
        end
`else
        eof_c = (bitcnt_q == LAST_BIT);
`endif
      end
`ifdef CRC8_EN
      ST_CRC: begin
        miso_c   = crc_q[7];
        busy_c   = 1'b1;
        crc_d    = {crc_q[6:0], 1'b0};
        bitcnt_d = bitcnt_q + CNT_W'(1);
        eof_c    = (bitcnt_q == CNT_W'(7));
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // Back-to-back frames reload on the last bit's edge with no gap
    if (eof_c) begin
      done_c = 1'b1;
      if (RD_CONT) load_c = 1'b1;
      else         state_d = ST_IDLE;
    end

    if (load_c && !abort_c) begin
      state_d     = ST_SHIFT;
      shreg_d     = ADC_data;
      bitcnt_d    = '0;
      pop_d       = 1'b1;
      drdy_load_d = drdy_s_q;
`ifdef CRC8_EN
      crc_d       = 8'h00;
`endif
    end

    // Abort wins over any load; the popped frame is simply dropped
    if (abort_c) state_d = ST_IDLE;
  end

  assign FIFO_POP     = pop_q;
  assign DRDY_AT_LOAD = drdy_load_q;
  assign MISO_data    = miso_c;
  assign BUSY         = busy_c;
  assign FRAME_DONE   = done_c;

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Scoreboard bench for fifo_frame_reader: a FIFO model feeds frames, a reference model
// predicts the serial stream per frame, and a negedge monitor compares every cycle.
module tb_fifo_frame_reader;

  localparam int FB = 128;
`ifdef CRC8_EN
  localparam int FL = FB + 8;
`else
  localparam int FL = FB;
`endif
  localparam logic [7:0] POLY = 8'h07;

  typedef struct packed {
    logic miso;
    logic pop;
    logic done;
    logic drdy;
  } exp_t;

  logic          SCK, RST_sync, ENSAMP_sync, DATA_RDY, RD_REQ, RD_CONT, RD_ABORT;
  logic [FB-1:0] ADC_data;
  logic          FIFO_POP, MISO_data, BUSY, FRAME_DONE, DRDY_AT_LOAD;

  logic [FB-1:0] fifo_mem [64];
  int            wr_ptr;
  int            rd_ptr = 0;
  int            model_rd;
  exp_t          exp_q[$];
  exp_t          mon_e;
  int            checks = 0;
  int            errors = 0;
  logic          mon_en;
  logic          rst_prev;

  fifo_frame_reader dut (
    .SCK          (SCK),
    .RST_sync     (RST_sync),
    .ENSAMP_sync  (ENSAMP_sync),
    .DATA_RDY     (DATA_RDY),
    .RD_REQ       (RD_REQ),
    .RD_CONT      (RD_CONT),
    .RD_ABORT     (RD_ABORT),
    .ADC_data     (ADC_data),
    .FIFO_POP     (FIFO_POP),
    .MISO_data    (MISO_data),
    .BUSY         (BUSY),
    .FRAME_DONE   (FRAME_DONE),
    .DRDY_AT_LOAD (DRDY_AT_LOAD)
  );

  initial SCK = 1'b0;
  always #5 SCK = ~SCK;

  // FIFO model: look-ahead head word, zeros when empty, advanced by FIFO_POP
  assign ADC_data = (rd_ptr < wr_ptr) ? fifo_mem[6'(rd_ptr)] : '0;
  always @(posedge SCK) if (FIFO_POP === 1'b1) rd_ptr <= rd_ptr + 1;

  // CRC as remainder of M(x)*x^8 divided by the generator polynomial
  function automatic logic [7:0] crc_ref(input logic [FB-1:0] d);
    logic [FB+7:0] r;
    r = {d, 8'h00};
    for (int i = FB + 7; i >= 8; i--)
      if (r[i]) r[i -: 9] = r[i -: 9] ^ {1'b1, POLY};
    return r[7:0];
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge SCK);
      #1;
    end
  endtask

  task automatic push_frame(input logic [FB-1:0] d);
    fifo_mem[6'(wr_ptr)] = d;
    wr_ptr++;
  endtask

  function automatic logic [FB-1:0] rand_frame();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Expected serial stream for the next frame leaving the FIFO
  task automatic expect_frame(input logic d);
    logic [FB-1:0] data;
    logic [7:0]    c;
    exp_t          e;
    data = fifo_mem[6'(model_rd)];
    model_rd++;
    c = crc_ref(data);
    for (int k = 0; k < FL; k++) begin
      if (k < FB) e.miso = data[FB-1-k];
      else        e.miso = c[7-(k-FB)];
      e.pop  = (k == 0);
      e.done = (k == FL - 1);
      e.drdy = d;
      exp_q.push_back(e);
    end
  endtask

  task automatic start_frame(input logic d);
    RD_REQ = 1'b1;
    tick();
    RD_REQ = 1'b0;
    expect_frame(d);
  endtask

  // n frames streamed back-to-back; DATA_RDY changes mid first frame
  task automatic run_frames(input int n, input logic d0, input logic d1);
    DATA_RDY = d0;
    RD_CONT  = (n > 1);
    tick(3);
    start_frame(d0);
    for (int i = 1; i < n; i++) expect_frame(d1);
    tick(59);
    DATA_RDY = d1;
    tick((n - 1) * FL + 5 - 59);
    RD_CONT = 1'b0;
    tick(FL - 5 + 2);
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Monitor: pops one expectation per BUSY cycle, otherwise checks the idle outputs
  initial begin
    rst_prev = 1'b0;
    forever begin
      @(negedge SCK);
      if (mon_en) begin
        if (rst_prev) chk("drdy_at_load_reset", DRDY_AT_LOAD, 1'b0);
        if (BUSY === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_busy at %0t: got BUSY=1 expected 0", $time);
          end else begin
            mon_e = exp_q.pop_front();
            chk("miso", MISO_data, mon_e.miso);
            chk("fifo_pop", FIFO_POP, mon_e.pop);
            chk("frame_done", FRAME_DONE, mon_e.done);
            chk("drdy_at_load", DRDY_AT_LOAD, mon_e.drdy);
          end
        end else begin
          chk("busy", BUSY, 1'(exp_q.size() != 0));
          chk("idle_miso", MISO_data, 1'b0);
          chk("idle_fifo_pop", FIFO_POP, 1'b0);
          chk("idle_frame_done", FRAME_DONE, 1'b0);
        end
      end
      rst_prev = RST_sync;
    end
  end

  initial begin
    int n;
    logic d0, d1;
    RST_sync    = 1'b1;
    ENSAMP_sync = 1'b0;
    DATA_RDY    = 1'b0;
    RD_REQ      = 1'b0;
    RD_CONT     = 1'b0;
    RD_ABORT    = 1'b0;
    wr_ptr      = 0;
    model_rd    = 0;
    mon_en      = 1'b0;
    tick();
    mon_en = 1'b1;
    tick(2);
    RST_sync    = 1'b0;
    ENSAMP_sync = 1'b1;
    tick(3);

    // Fixed patterns: alternating nibbles, single LSB, all zeros
    push_frame({16{8'hA5}});
    run_frames(1, 1'b1, 1'b0);
    push_frame(128'h1);
    run_frames(1, 1'b0, 1'b1);
    push_frame('0);
    run_frames(1, 1'b1, 1'b1);

    // Three frames streamed continuously, then random runs
    for (int i = 0; i < 3; i++) push_frame(rand_frame());
    run_frames(3, 1'b0, 1'b1);
    repeat (4) begin
      n  = int'($urandom_range(1, 3));
      d0 = 1'($urandom);
      d1 = 1'($urandom);
      for (int i = 0; i < n; i++) push_frame(rand_frame());
      run_frames(n, d0, d1);
    end

    // Abort at bit 60 with continuation requested; second frame must stay queued
    push_frame(rand_frame());
    push_frame(rand_frame());
    DATA_RDY = 1'b1;
    RD_CONT  = 1'b1;
    tick(3);
    start_frame(1'b1);
    tick(60);
    RD_ABORT = 1'b1;
    tick();
    RD_ABORT = 1'b0;
    exp_q.delete();
    tick(5);
    RD_CONT  = 1'b0;
    RD_ABORT = 1'b1;
    RD_REQ   = 1'b1;
    tick();
    RD_ABORT = 1'b0;
    RD_REQ   = 1'b0;
    tick(3);

    // Requests ignored while sampling is disabled
    ENSAMP_sync = 1'b0;
    tick(3);
    repeat (3) begin
      RD_REQ = 1'b1;
      tick();
      RD_REQ = 1'b0;
      tick(2);
    end
    ENSAMP_sync = 1'b1;
    tick(4);

    // Sampling enable dropped mid-frame: busy for exactly three more cycles
    start_frame(1'b1);
    tick(49);
    ENSAMP_sync = 1'b0;
    tick(3);
    exp_q.delete();
    ENSAMP_sync = 1'b1;
    tick(4);

    // Reset at bit 40, then a clean restart
    push_frame(rand_frame());
    start_frame(1'b1);
    tick(40);
    RST_sync = 1'b1;
    tick();
    exp_q.delete();
    tick();
    RST_sync = 1'b0;
    tick(3);
    push_frame(rand_frame());
    run_frames(1, 1'b0, 1'b1);

    tick(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_frame_reader.md
# fifo_frame_reader

SCK-domain consumer at the read end of the ADC frame FIFO. On a streaming-read request from the SPI command decoder, it captures the FIFO's look-ahead 128-bit frame into a shift register and issues a single-cycle FIFO_POP. It then serialises the frame MSB-first, one bit per SCK, to the SPI output stage, with an optional CRC-8 trailer. Frames can be streamed back-to-back.

## Interface
- FRAME_BITS, 128, frame width; must equal the FIFO's ADC_data width.
- CRC_POLY, 8'h07, CRC-8 polynomial (x^8+x^2+x+1); used only with CRC8 compiled in.
- SCK  in  1  sole clock; all logic on posedge.
- RST_sync  in  1  reset, synchronous and active-high.
- ENSAMP_sync  in  1  sampling enable, foreign domain; 2-flop synchronised internally to ens_s.
- DATA_RDY  in  1  FIFO watermark flag, foreign domain; 2-flop synchronised to drdy_s.
- RD_REQ  in  1  one-cycle pulse: start streaming read.
- RD_CONT  in  1  level: continue with the next frame after the current one.
- RD_ABORT  in  1  chip-select deassert: abandon the transfer.
- ADC_data  in  FRAME_BITS  FIFO look-ahead frame; zeros when the FIFO is empty.
- FIFO_POP  out  1  one-SCK pulse that advances the FIFO read pointer.
- MISO_data  out  1  current serial bit to the SPI pad stage.
- BUSY  out  1  high while in SHIFT or CRC.
- FRAME_DONE  out  1  one-cycle pulse on the last bit of each frame, CRC included.
- DRDY_AT_LOAD  out  1  drdy_s value captured at each frame load.

## Operation
- States: IDLE, SHIFT, CRC. CRC exists only with CRC8_EN.
- **IDLE:**
  - On RD_REQ && ens_s && !RD_ABORT: shreg <= ADC_data, bitcnt <= 0, FIFO_POP <= 1, DRDY_AT_LOAD <= drdy_s, crc <= 8'h00; go to SHIFT.
  - RD_REQ is ignored while ens_s is low.
- **SHIFT:**
  - MISO_data = shreg[FRAME_BITS-1] (combinational from the register). Each cycle: shreg <<= 1, bitcnt++.
  - With CRC8_EN, crc updates serially on the transmitted bit: fb = crc[7]^bit; crc = {crc[6:0],1'b0} ^ (fb ? CRC_POLY : 0).
  - On bitcnt == FRAME_BITS-1:
    - With CRC8_EN: go to CRC, bitcnt <= 0.
    - Without CRC8_EN: end of frame (below).
- **CRC:** MISO_data = crc[7]; crc shifts left by 1 each cycle; end of frame on bitcnt == 7.
- **End of frame:**
  - FRAME_DONE = 1.
  - If RD_CONT && ens_s: reload in that same edge, exactly as for an IDLE request, and stay in SHIFT. There is no gap bit.
  - Otherwise go to IDLE.
- **Abort:** RD_ABORT or !ens_s in any state → IDLE on the next edge. FIFO_POP is forced to 0 and no further pop is issued. A frame already popped is discarded, not re-queued.
- RD_REQ while BUSY is ignored.
- MISO_data is 0 in IDLE.
- FIFO_POP is never high for two consecutive cycles. The FIFO advances one frame per cycle of FIFO_POP.
- bitcnt is $clog2(FRAME_BITS) bits wide and wraps to 0 at reload. No other arithmetic widens.

## Timing
- Reset values: FIFO_POP=0, MISO_data=0, BUSY=0, FRAME_DONE=0, DRDY_AT_LOAD=0, state=IDLE, shreg=0, crc=0, sync flops=0.
- **Request to data:**
  - RD_REQ sampled at edge 0.
  - FIFO_POP and BUSY are high during cycle 1.
  - Frame bit k (k=0 is bit 127) drives MISO_data in cycle 1+k.
  - FRAME_DONE is high in cycle 128 without CRC; CRC bits occupy cycles 129..136 with FRAME_DONE in 136.
- The FIFO's ADC_data reflects the popped pointer 2 SCK cycles after FIFO_POP. The ≥128-cycle frame length guarantees fresh data at the next load.
- ENSAMP_sync and DATA_RDY are seen 2 SCK cycles late; the abort on ENSAMP drop therefore lags by 2 cycles.
- Simultaneous events:
  - RD_ABORT beats RD_REQ and RD_CONT.
  - An end-of-frame reload and an abort in the same cycle give an abort with no pop.

## Configuration
- CRC8_EN defined: the CRC state is present and each frame is followed by an 8-bit CRC (init 0x00, no final XOR, MSB-first); frame period is FRAME_BITS+8 cycles.
- CRC8_EN undefined: no CRC logic or state; frame period is FRAME_BITS cycles; FRAME_DONE falls on the last data bit.

## Test plan
- Reset mid-SHIFT (RST_sync at bit 40) → next cycle all outputs 0, state IDLE; a later RD_REQ restarts from bit 127.
- ADC_data=128'hA5...A5, RD_REQ → FIFO_POP high only in cycle 1; MISO_data sequence 1,0,1,0,0,1,0,1,… over 128 cycles; FRAME_DONE in cycle 128 (no CRC).
- CRC8_EN, ADC_data=128'h1 → 127 zeros, then a 1, then trailer 0x07 (00000111); FRAME_DONE in cycle 136. With ADC_data=0 the trailer is 0x00.
- RD_CONT held high over 3 frames → FIFO_POP at cycles 1, 129, 257; MISO_data continuous with no idle cycle; BUSY never drops.
- RD_ABORT at bit 60 with RD_CONT high → IDLE next cycle, MISO_data=0, no further FIFO_POP; RD_REQ together with RD_ABORT in IDLE → no pop.
- ENSAMP_sync low with RD_REQ pulsing → no FIFO_POP and BUSY stays 0; ENSAMP_sync falling mid-frame → IDLE 3 cycles later.
